// File: rtl/uart_reg_slave_if.sv
// Serial line and register-write/status bundle between the UART command
// master side and the uart_reg_slave endpoint.
interface uart_reg_slave_if;
    logic       rx;
    logic       tx;
    logic       reg_wr_en;
    logic [6:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic       err_parity;
    logic       err_frame;
    logic       busy;

    modport slave (
        input  rx,
        output tx,
        output reg_wr_en,
        output reg_wr_addr,
        output reg_wr_data,
        output err_parity,
        output err_frame,
        output busy
    );

    modport master (
        output rx,
        input  tx,
        input  reg_wr_en,
        input  reg_wr_addr,
        input  reg_wr_data,
        input  err_parity,
        input  err_frame,
        input  busy
    );
endinterface

// File: rtl/uart_reg_slave.sv
// Device-side endpoint of the two-byte UART command link: receives {rw,addr}
// plus data, writes a local register file, and answers reads with one frame.
module uart_reg_slave #(
    parameter int BR        = 434,
    parameter int REG_DEPTH = 16,
    parameter int TA_DLY    = 64,
    parameter int TO_CYC    = 8192
) (
    input  logic              clk,
    input  logic              rst,
    uart_reg_slave_if.slave   bus
);

    localparam int BCW = (BR < 1) ? 1 : $clog2(BR + 1);
    localparam int TCW = $clog2(TO_CYC);
    localparam int ACW = $clog2(TA_DLY);
    localparam int AW  = $clog2(REG_DEPTH);

    localparam logic [BCW-1:0] BRV     = BCW'(BR);
    localparam logic [BCW-1:0] HALF    = BCW'(BR / 2);
    localparam logic [TCW-1:0] TO_LAST = TCW'(TO_CYC - 1);
    localparam logic [ACW-1:0] TA_LAST = ACW'(TA_DLY - 1);

    typedef enum logic [3:0] {
        WAIT_B0, RX_B0, WAIT_B1, RX_B1, EXEC, TURN,
        TX_START, TX_DATA, TX_PAR, TX_STOP
    } state_e;

    function automatic logic odd_par(input logic [7:0] d);
        return ~^d;
    endfunction

    state_e         state_q, state_d;
    logic [BCW-1:0] baud_q, baud_d;
    logic [3:0]     bit_q, bit_d;
    logic [TCW-1:0] to_q, to_d;
    logic [ACW-1:0] ta_q, ta_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_q, par_d;
    logic [7:0]     cmd_q, cmd_d;
    logic [7:0]     resp_q, resp_d;
    logic           wr_en_q, wr_en_d;
    logic [6:0]     wr_addr_q, wr_addr_d;
    logic [7:0]     wr_data_q, wr_data_d;
    logic           perr_q, perr_d;
    logic           ferr_q, ferr_d;
    logic           busy_q, busy_d;
    logic           tx_q, tx_d;
    logic           rx_s1_q, rx_s2_q, rx_s3_q;
    logic [7:0]     regs_q [REG_DEPTH];

    logic rx_s, start_s, rx_tick_s, in_range_s;

    assign rx_s       = rx_s2_q;
    assign start_s    = rx_s3_q & ~rx_s2_q;
    assign in_range_s = (32'(cmd_q[6:0]) < REG_DEPTH);

    // rx synchroniser plus history flop for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
        end else begin
            rx_s1_q <= bus.rx;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
        end
    end

    // next-state logic for receive, execute, turnaround and transmit
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        to_d      = to_q;
        ta_d      = ta_q;
        shift_d   = shift_q;
        par_d     = par_q;
        cmd_d     = cmd_q;
        resp_d    = resp_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        rx_tick_s = 1'b0;
        case (state_q)
            WAIT_B0: begin
                if (start_s) begin
                    state_d = RX_B0;
                    baud_d  = '0;
                    bit_d   = 4'd0;
                end else begin
                    state_d = WAIT_B0;
                end
            end
            RX_B0, RX_B1: begin
                // bit 0 is the half-bit start re-check; 1..8 data, 9 parity, 10 stop
                if (bit_q == 4'd0) begin
                    rx_tick_s = (baud_q == HALF);
                end else begin
                    rx_tick_s = (baud_q == BRV);
                end
                if (!rx_tick_s) begin
                    baud_d = baud_q + BCW'(1);
                end else begin
                    baud_d = '0;
                    bit_d  = bit_q + 4'd1;
                    case (bit_q)
                        4'd0: begin
                            if (rx_s) begin
                                state_d = (state_q == RX_B0) ? WAIT_B0 : WAIT_B1;
                            end else begin
                                state_d = state_q;
                            end
                        end
                        4'd9: par_d = rx_s;
                        4'd10: begin
                            perr_d = (par_q != odd_par(shift_q));
                            ferr_d = ~rx_s;
                            if (perr_d || ferr_d) begin
                                state_d = WAIT_B0;
                            end else if (state_q == RX_B0) begin
                                cmd_d   = shift_q;
                                to_d    = '0;
                                state_d = WAIT_B1;
                            end else begin
                                state_d   = EXEC;
                                wr_en_d   = cmd_q[7] & in_range_s;
                                wr_addr_d = cmd_q[6:0];
                                wr_data_d = shift_q;
                            end
                        end
                        default: shift_d = {rx_s, shift_q[7:1]};
                    endcase
                end
            end
            WAIT_B1: begin
                if (start_s) begin
                    state_d = RX_B1;
                    baud_d  = '0;
                    bit_d   = 4'd0;
                end else if (to_q == TO_LAST) begin
                    state_d = WAIT_B0;
                end else begin
                    to_d = to_q + TCW'(1);
                end
            end
            EXEC: begin
                if (cmd_q[7]) begin
                    state_d = WAIT_B0;
                end else begin
                    resp_d  = in_range_s ? regs_q[cmd_q[AW-1:0]] : 8'h00;
                    ta_d    = '0;
                    state_d = TURN;
                end
            end
            TURN: begin
                if (ta_q == TA_LAST) begin
                    state_d = TX_START;
                    baud_d  = '0;
                end else begin
                    ta_d = ta_q + ACW'(1);
                end
            end
            TX_START: begin
                if (baud_q == BRV) begin
                    state_d = TX_DATA;
                    baud_d  = '0;
                    bit_d   = 4'd0;
                end else begin
                    baud_d = baud_q + BCW'(1);
                end
            end
            TX_DATA: begin
                if (baud_q == BRV) begin
                    baud_d = '0;
                    if (bit_q == 4'd7) begin
                        state_d = TX_PAR;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + BCW'(1);
                end
            end
            TX_PAR: begin
                if (baud_q == BRV) begin
                    state_d = TX_STOP;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + BCW'(1);
                end
            end
            TX_STOP: begin
                if (baud_q == BRV) begin
                    state_d = WAIT_B0;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + BCW'(1);
                end
            end
            default: state_d = WAIT_B0;
        endcase
    end

    // tx and busy are decoded from the next state so they are registered outputs
    always_comb begin
        busy_d = (state_d != WAIT_B0);
        case (state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = resp_q[bit_d[2:0]];
            TX_PAR:   tx_d = odd_par(resp_q);
            default:  tx_d = 1'b1;
        endcase
    end

    // control state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= WAIT_B0;
            baud_q    <= '0;
            bit_q     <= 4'd0;
            to_q      <= '0;
            ta_q      <= '0;
            shift_q   <= 8'h00;
            par_q     <= 1'b0;
            cmd_q     <= 8'h00;
            resp_q    <= 8'h00;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 7'h00;
            wr_data_q <= 8'h00;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            to_q      <= to_d;
            ta_q      <= ta_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            cmd_q     <= cmd_d;
            resp_q    <= resp_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
            tx_q      <= tx_d;
        end
    end

    // register file; the write commits at the end of EXEC
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if ((state_q == EXEC) && wr_en_q) begin
            regs_q[wr_addr_q[AW-1:0]] <= wr_data_q;
        end
    end

    assign bus.tx          = tx_q;
    assign bus.reg_wr_en   = wr_en_q;
    assign bus.reg_wr_addr = wr_addr_q;
    assign bus.reg_wr_data = wr_data_q;
    assign bus.err_parity  = perr_q;
    assign bus.err_frame   = ferr_q;
    assign bus.busy        = busy_q;

endmodule
